// File: rtl/seg_readback_if.sv
// Byte stream from seg_readback to its consumer.
//   out_valid : byte available (master -> slave)
//   out_ready : consumer accepts the byte (slave -> master)
//   out_addr  : data-memory address the byte was read from
//   out_data  : {high nibble, low nibble}
//   out_err   : decode or echo error seen while sampling this byte
interface seg_readback_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       out_err;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seg_readback.sv
// Sweeps the processor's 16 data-memory addresses through its seven-segment
// readout port, decodes the high and low nibble patterns and streams one byte
// per address on a valid/ready interface.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   start               : one-cycle sweep request (ignored while busy)
//   busy, done          : sweep in progress / one-cycle end-of-sweep pulse
//   display_on, lsB     : processor ui_in[0] / ui_in[1] (0 = high nibble)
//   addr                : processor ui_in[5:2]
//   seg_in, seg_lsb_in  : processor uo_out[6:0] segments / uo_out[7] echo
//   out_if              : decoded byte stream (master side)
//   err_any             : sticky error flag, cleared by an accepted start
module seg_readback #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  display_on,
    output logic                  lsB,
    output logic [3:0]            addr,
    input  logic [6:0]            seg_in,
    input  logic                  seg_lsb_in,
    seg_readback_if.master        out_if,
    output logic                  err_any
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SETTLE_HI = 2'd1;
    localparam logic [1:0] ST_SETTLE_LO = 2'd2;
    localparam logic [1:0] ST_EMIT      = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       addr_q,     addr_d;
    logic             lsb_q,      lsb_d;
    logic             disp_q,     disp_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             valid_q,    valid_d;
    logic [3:0]       out_addr_q, out_addr_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_err_q,  out_err_d;
    logic             err_any_q,  err_any_d;
    logic [3:0]       hi_nib_q,   hi_nib_d;
    logic             hi_err_q,   hi_err_d;

    logic [4:0]       dec_c;
    logic             sample_c;
    logic             echo_bad_c;

    // Pattern to {error, nibble}; unknown patterns decode to 0 with error set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign dec_c      = seg_decode(seg_in);
    assign sample_c   = (cnt_q == CNT_W'(SETTLE_CYCLES));
    assign echo_bad_c = (seg_lsb_in != lsb_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        lsb_d      = lsb_q;
        disp_d     = disp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        err_any_d  = err_any_q;
        hi_nib_d   = hi_nib_q;
        hi_err_d   = hi_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = 4'd0;
                    lsb_d     = 1'b0;
                    disp_d    = 1'b1;
                    busy_d    = 1'b1;
                    err_any_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_SETTLE_HI;
                end
            end
            ST_SETTLE_HI: begin
                if (sample_c) begin
                    hi_nib_d = dec_c[3:0];
                    hi_err_d = dec_c[4] | echo_bad_c;
                    lsb_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SETTLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE_LO: begin
                if (sample_c) begin
                    out_data_d = {hi_nib_q, dec_c[3:0]};
                    out_err_d  = hi_err_q | dec_c[4] | echo_bad_c;
                    out_addr_d = addr_q;
                    valid_d    = 1'b1;
                    state_d    = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (valid_q && out_if.out_ready) begin
                    valid_d   = 1'b0;
                    err_any_d = err_any_q | out_err_q;
                    lsb_d     = 1'b0;
                    if (addr_q != 4'hF) begin
                        addr_d  = addr_q + 4'd1;
                        cnt_d   = '0;
                        state_d = ST_SETTLE_HI;
                    end else begin
                        addr_d  = 4'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        disp_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= 4'd0;
            lsb_q      <= 1'b0;
            disp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_addr_q <= 4'd0;
            out_data_q <= 8'h00;
            out_err_q  <= 1'b0;
            err_any_q  <= 1'b0;
            hi_nib_q   <= 4'd0;
            hi_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            lsb_q      <= lsb_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            err_any_q  <= err_any_d;
            hi_nib_q   <= hi_nib_d;
            hi_err_q   <= hi_err_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign display_on       = disp_q;
    assign lsB              = lsb_q;
    assign addr             = addr_q;
    assign err_any          = err_any_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_err   = out_err_q;

endmodule

// File: tb/tb_seg_readback.sv
// Self-checking bench for seg_readback: a behavioural processor readout model
// driven from a per-address vector table, a beat monitor, and directed sweeps.
module tb_seg_readback;

    localparam int unsigned S    = 4;
    localparam int          BEAT = 2 * S + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, display_on, lsB, err_any;
    logic [3:0] addr;
    logic [6:0] seg_in;
    logic       seg_lsb_in;

    seg_readback_if rb_if();

    seg_readback #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .display_on (display_on),
        .lsB        (lsB),
        .addr       (addr),
        .seg_in     (seg_in),
        .seg_lsb_in (seg_lsb_in),
        .out_if     (rb_if),
        .err_any    (err_any)
    );

    always #5 clk = ~clk;

    // Per-address stimulus (memory value, faults) and expected beat.
    typedef struct {
        logic [7:0] mem;
        logic       bad_lo;
        logic       bad_echo;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } beat_t;

    vec_t  tab [16];
    beat_t beats [$];
    int    cyc = 0;
    int    done_cnt = 0;
    int    checks = 0;
    int    errors = 0;
    logic [3:0] nib_sel;

    function automatic logic [6:0] enc7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Processor readout model with table-controlled fault injection.
    always_comb begin
        nib_sel    = lsB ? tab[addr].mem[3:0] : tab[addr].mem[7:4];
        seg_in     = display_on ? enc7(nib_sel) : 7'h00;
        seg_lsb_in = lsB;
        if (display_on && lsB && tab[addr].bad_lo)
            seg_in = 7'h00;
        if (display_on && !lsB && tab[addr].bad_echo)
            seg_lsb_in = 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Beat and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && rb_if.out_valid && rb_if.out_ready)
            beats.push_back('{addr: rb_if.out_addr, data: rb_if.out_data,
                              err: rb_if.out_err, cyc: cyc});
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"},       32'(busy),             32'd0);
        check({tag, " done"},       32'(done),             32'd0);
        check({tag, " display_on"}, 32'(display_on),       32'd0);
        check({tag, " lsB"},        32'(lsB),              32'd0);
        check({tag, " addr"},       32'(addr),             32'd0);
        check({tag, " out_valid"},  32'(rb_if.out_valid),  32'd0);
        check({tag, " out_err"},    32'(rb_if.out_err),    32'd0);
        check({tag, " err_any"},    32'(err_any),          32'd0);
        check({tag, " out_addr"},   32'(rb_if.out_addr),   32'd0);
        check({tag, " out_data"},   32'(rb_if.out_data),   32'd0);
    endtask

    // Table of plain memory contents; hi_rev puts 15-i in the high nibble.
    task automatic fill_plain(input bit hi_rev);
        for (int i = 0; i < 16; i++) begin
            tab[i].mem      = hi_rev ? {4'(15 - i), 4'(i)} : 8'(8'h10 + i);
            tab[i].bad_lo   = 1'b0;
            tab[i].bad_echo = 1'b0;
            tab[i].exp_data = tab[i].mem;
            tab[i].exp_err  = 1'b0;
        end
    endtask

    task automatic pulse_start(output int c);
        start = 1'b1;
        c     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_addr(input logic [3:0] a, input string name);
        int n = 0;
        while (addr !== a && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(addr), 32'(a));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic compare_beats(input string tag, input int b0, input int c0, input int stall_idx);
        int    n;
        int    prev;
        int    gap_exp;
        beat_t b;
        n = beats.size() - b0;
        check({tag, " beat count"}, 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                b       = beats[b0 + i];
                prev    = (i == 0) ? c0 : beats[b0 + i - 1].cyc;
                gap_exp = BEAT + ((i == stall_idx) ? 7 : 0);
                check($sformatf("%s beat%0d addr", tag, i), 32'(b.addr), 32'(i));
                check($sformatf("%s beat%0d data", tag, i), 32'(b.data), 32'(tab[i].exp_data));
                check($sformatf("%s beat%0d err", tag, i),  32'(b.err),  32'(tab[i].exp_err));
                check($sformatf("%s beat%0d gap", tag, i),  32'(b.cyc - prev), 32'(gap_exp));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          b0, c0, d0, n, changes;
        logic [31:0] snap, snap0;

        rb_if.out_ready = 1'b1;
        fill_plain(1'b0);

        // Reset held for 10 cycles, then released; outputs must stay static.
        repeat (10) tick();
        check_reset("in reset");
        rst_n = 1'b1;
        tick();
        check_reset("after reset");
        snap0   = {8'(rb_if.out_data), 4'(rb_if.out_addr), 4'(addr), busy, done, display_on,
                   lsB, rb_if.out_valid, rb_if.out_err, err_any, 9'd0};
        changes = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            snap = {8'(rb_if.out_data), 4'(rb_if.out_addr), 4'(addr), busy, done, display_on,
                    lsB, rb_if.out_valid, rb_if.out_err, err_any, 9'd0};
            if (snap !== snap0) changes++;
        end
        check("idle static changes", 32'(changes), 32'd0);

        // Sweep A: clean data, stray start at addr 2, backpressure at addr 3.
        fill_plain(1'b0);
        b0 = beats.size();
        d0 = done_cnt;
        pulse_start(c0);
        check("A busy after start", 32'(busy), 32'd1);
        check("A display_on", 32'(display_on), 32'd1);
        check("A addr start", 32'(addr), 32'd0);
        wait_addr(4'd2, "A reach addr2");
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_addr(4'd3, "A reach addr3");
        rb_if.out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (rb_if.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("A stall valid seen", 32'(rb_if.out_valid), 32'd1);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("A stall%0d valid", k),    32'(rb_if.out_valid), 32'd1);
            check($sformatf("A stall%0d out_addr", k), 32'(rb_if.out_addr),  32'd3);
            check($sformatf("A stall%0d out_data", k), 32'(rb_if.out_data),  32'h13);
            check($sformatf("A stall%0d addr", k),     32'(addr),            32'd3);
            if (k < 6) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rb_if.out_ready = 1'b1;
        wait_done("A done");
        check("A busy at done", 32'(busy), 32'd0);
        check("A display_on at done", 32'(display_on), 32'd0);
        tick();
        check("A done one cycle", 32'(done), 32'd0);
        check("A done count", 32'(done_cnt - d0), 32'd1);
        check("A err_any", 32'(err_any), 32'd0);
        compare_beats("A", b0, c0, 3);

        // Sweep B: bad low pattern at addr 5, echo mismatch on high sample at addr 9.
        fill_plain(1'b0);
        tab[5].bad_lo   = 1'b1;
        tab[5].exp_data = 8'h10;
        tab[5].exp_err  = 1'b1;
        tab[9].bad_echo = 1'b1;
        tab[9].exp_data = 8'h19;
        tab[9].exp_err  = 1'b1;
        b0 = beats.size();
        pulse_start(c0);
        wait_addr(4'd5, "B reach addr5");
        check("B err_any before beat5", 32'(err_any), 32'd0);
        wait_addr(4'd6, "B reach addr6");
        check("B err_any after beat5", 32'(err_any), 32'd1);
        wait_done("B done");
        check("B err_any at done", 32'(err_any), 32'd1);
        compare_beats("B", b0, c0, -1);

        // Sweep C: start in the cycle after done, then reset during EMIT of addr 7.
        tick();
        check("B err_any held", 32'(err_any), 32'd1);
        fill_plain(1'b0);
        b0 = beats.size();
        d0 = done_cnt;
        pulse_start(c0);
        check("C err_any cleared", 32'(err_any), 32'd0);
        check("C busy", 32'(busy), 32'd1);
        n = 0;
        while (!(rb_if.out_valid === 1'b1 && rb_if.out_addr === 4'd7) && n < 300) begin
            tick();
            n++;
        end
        check("C emit addr7 reached", 32'(rb_if.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("C async reset");
        repeat (3) tick();
        check("C beats before reset", 32'(beats.size() - b0), 32'd7);
        check("C no done", 32'(done_cnt - d0), 32'd0);
        rst_n = 1'b1;
        tick();
        check_reset("C after release");

        // Sweep D: fresh start after reset, high nibble walks F..0.
        fill_plain(1'b1);
        b0 = beats.size();
        d0 = done_cnt;
        pulse_start(c0);
        check("D addr start", 32'(addr), 32'd0);
        wait_done("D done");
        tick();
        check("D done count", 32'(done_cnt - d0), 32'd1);
        check("D busy after", 32'(busy), 32'd0);
        compare_beats("D", b0, c0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_readback.md
# seg_readback

Downstream consumer of the tiny processor's seven-segment readout port. After a `start` pulse, the block sweeps all 16 data-memory addresses by driving the processor's `display_on`, `lsB` and `addr_in` inputs. For each address it samples the high-nibble and low-nibble segment patterns and decodes them to hex. It then emits one byte per address on a valid/ready stream, so the FPGA demo can verify program results without reading the segments manually.

## Interface
- `SETTLE_CYCLES`, default 4: cycles waited after any `addr`/`lsB` change before sampling `seg_in`. Legal range is ≥1.
- `clk`  in  1  — system clock; same clock that feeds the processor.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — one-cycle request to begin a sweep. Ignored while `busy`=1.
- `busy`  out  1  — high from the cycle after an accepted `start` until `done`.
- `done`  out  1  — one-cycle pulse marking the end of a sweep.
- `display_on`  out  1  — drives processor `ui_in[0]`.
- `lsB`  out  1  — drives processor `ui_in[1]`. 0 selects the high nibble, 1 selects the low nibble.
- `addr`  out  4  — drives processor `ui_in[5:2]`.
- `seg_in`  in  7  — processor `uo_out[6:0]`, active high; bit0=a … bit6=g.
- `seg_lsb_in`  in  1  — processor `uo_out[7]`, echo of the selected nibble.
- `out_valid`  out  1  — decoded byte available.
- `out_ready`  in  1  — consumer accepts the byte.
- `out_addr`  out  4  — address of the byte.
- `out_data`  out  8  — {high nibble, low nibble}.
- `out_err`  out  1  — this byte had a decode or echo error.
- `err_any`  out  1  — sticky error flag, cleared when a `start` is accepted.

## Operation
- States: IDLE, SETTLE_HI, SETTLE_LO, EMIT.
- IDLE, `start`=1:
  - `addr`←0, `lsB`←0, `display_on`←1, `busy`←1, `err_any`←0.
  - Settle counter ←0; next state SETTLE_HI.
- SETTLE_HI / SETTLE_LO: the counter increments each cycle. On the edge where counter==`SETTLE_CYCLES`, `seg_in` is sampled and decoded.
  - Leaving SETTLE_HI: high nibble latched, `lsB`←1, counter←0, go to SETTLE_LO.
  - Leaving SETTLE_LO: low nibble latched, `out_valid`←1, go to EMIT.
- Decode table (pattern→nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7.
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - Any other pattern → nibble 0 and sets the byte's error.
- Echo check: the byte's error is also set if `seg_lsb_in`≠`lsB` at either sample edge.
- `out_err` = OR of all errors for the byte. `err_any` |= `out_err` when the byte is accepted.
- EMIT: `out_valid`, `out_addr`, `out_data` and `out_err` are held stable until `out_valid`&&`out_ready` at a clock edge. Acceptance edge:
  - If `addr`<15: `addr`+1, `lsB`←0, counter←0, go to SETTLE_HI.
  - If `addr`==15: `done`←1 for one cycle, `busy`←0, `display_on`←0, `addr`←0, `lsB`←0, go to IDLE.
- `addr` never wraps within a sweep. There are exactly 16 beats per sweep.

## Timing
- Reset values:
  - `busy`, `done`, `display_on`, `lsB`, `out_valid`, `out_err`, `err_any` = 0.
  - `addr`, `out_addr` = 0; `out_data` = 0x00.
  - State = IDLE.
- Reset assertion at any point, including mid-sweep or during EMIT, returns everything to reset values asynchronously. No partial beat is emitted afterwards.
- All outputs are registered.
- Let E0 be the edge that changes `addr`/`lsB` to 0. With `SETTLE_CYCLES`=S:
  - High sample at E0+S+1.
  - Low sample at E0+2S+2.
  - `out_valid` high starting after edge E0+2S+2.
- Byte period with `out_ready` held high is 2S+3 cycles: 2S+2 cycles settling plus 1 EMIT cycle. That is 11 cycles for S=4.
- `start` coincident with `busy`=1 has no effect. `start` and reset together: reset wins.
- `done` is asserted in the cycle following the final acceptance edge. `start` is accepted again in the cycle after `done`.

## Test plan
- Reset: hold `rst_n`=0 for 10 cycles, then release. All outputs equal their reset values; `start` absent → outputs remain static for 50 cycles.
- Full sweep, S=4, `out_ready`=1, processor memory loaded with value 0x10+i at address i:
  - 16 beats, `out_addr` 0..15, `out_data` 0x10..0x1F, `out_err`=0.
  - Beats spaced 11 cycles apart; `done` pulses once; `busy`=0 afterwards.
- Backpressure: hold `out_ready`=0 for 7 cycles at addr 3.
  - `out_valid`, `out_addr`=3 and `out_data` stay stable.
  - `addr` output stays at 3; the next beat arrives 11 cycles after the accepting edge.
- Invalid pattern: force `seg_in`=0x00 during the low sample of addr 5.
  - Beat 5 carries `out_data` high nibble intact, low nibble 0, `out_err`=1; `err_any`=1.
  - `err_any` stays 1 through the end of the sweep and clears on the next accepted `start`.
- Echo mismatch: force `seg_lsb_in`=1 during the high sample of addr 9. Beat 9 has `out_err`=1; all other beats have `out_err`=0.
- Control edge cases:
  - Pulse `start` at beat 2: no effect on the sweep.
  - Assert `rst_n`=0 during EMIT of addr 7: all outputs return to reset values immediately, and no beat 7 is emitted.
  - A new `start` after reset sweeps again from addr 0.
